// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin values and the coin-select encoding used on the change path.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } vend_state_t;

    localparam int VAL_QUARTER = 25;
    localparam int VAL_DIME    = 10;
    localparam int VAL_NICKEL  = 5;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_QUARTER,
        COIN_DIME,
        COIN_NICKEL
    } coin_sel_t;

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: picks the largest coin not exceeding the
// remaining credit and reports its value.
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic [CW-1:0] credit_i,
    output coin_sel_t     coin_o,
    output logic [CW-1:0] value_o
);

    always_comb begin
        coin_o  = COIN_NONE;
        value_o = '0;
        if (credit_i >= CW'(VAL_QUARTER)) begin
            coin_o  = COIN_QUARTER;
            value_o = CW'(VAL_QUARTER);
        end else if (credit_i >= CW'(VAL_DIME)) begin
            coin_o  = COIN_DIME;
            value_o = CW'(VAL_DIME);
        end else if (credit_i != '0) begin
            // Credit is always a multiple of 5, so anything left here is one nickel.
            coin_o  = COIN_NICKEL;
            value_o = CW'(VAL_NICKEL);
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: accumulates coin credit, dispenses at PRICE and pays
// change greedily one coin per cycle. All outputs are registered.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 125,
    parameter int MAX_CREDIT = 500,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inQuarter,
    input  logic          inDime,
    input  logic          inNickel,
    input  logic          inSelect,
    input  logic          inCancel,
    output logic [CW-1:0] outCredit,
    output logic          outDispense,
    output logic          outChangeQuarter,
    output logic          outChangeDime,
    output logic          outChangeNickel,
    output logic          outReject,
    output logic          outBusy
);

    vend_state_t   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          dispense_q, dispense_d;
    logic          chq_q, chq_d, chd_q, chd_d, chn_q, chn_d;
    logic          reject_q, reject_d;
    logic          busy_q, busy_d;

    logic          coin_any, coin_multi, coin_ok;
    logic [CW-1:0] coin_value;
    logic [CW:0]   credit_sum;
    coin_sel_t     chg_coin;
    logic [CW-1:0] chg_value;

    vend_change_sel #(.CW(CW)) u_change_sel (
        .credit_i (credit_q),
        .coin_o   (chg_coin),
        .value_o  (chg_value)
    );

    assign coin_any   = inQuarter | inDime | inNickel;
    assign coin_multi = (inQuarter & inDime) | (inQuarter & inNickel) | (inDime & inNickel);
    assign coin_value = inQuarter ? CW'(VAL_QUARTER) :
                        inDime    ? CW'(VAL_DIME)    :
                        inNickel  ? CW'(VAL_NICKEL)  : '0;
    // One extra bit so a coin on top of a full register cannot wrap past the limit check.
    assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ok    = coin_any && !coin_multi && (credit_sum <= (CW+1)'(MAX_CREDIT));

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = 1'b0;
        chq_d      = 1'b0;
        chd_d      = 1'b0;
        chn_d      = 1'b0;
        reject_d   = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                if (state_q == CREDIT && inCancel) begin
                    // Refund starts immediately: the first change coin leaves on this edge.
                    reject_d = coin_any;
                    credit_d = credit_q - chg_value;
                    chq_d    = (chg_coin == COIN_QUARTER);
                    chd_d    = (chg_coin == COIN_DIME);
                    chn_d    = (chg_coin == COIN_NICKEL);
                    state_d  = (credit_q == chg_value) ? IDLE : CHANGE;
                end else if (coin_any) begin
                    if (coin_ok) begin
                        credit_d = credit_sum[CW-1:0];
                        state_d  = CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (state_q == CREDIT && inSelect && credit_q >= CW'(PRICE)) begin
                    dispense_d = 1'b1;
                    credit_d   = credit_q - CW'(PRICE);
                    state_d    = VEND;
                end
            end
            VEND, CHANGE: begin
                reject_d = coin_any;
                credit_d = credit_q - chg_value;
                chq_d    = (chg_coin == COIN_QUARTER);
                chd_d    = (chg_coin == COIN_DIME);
                chn_d    = (chg_coin == COIN_NICKEL);
                state_d  = (credit_q == chg_value) ? IDLE : CHANGE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            chq_q      <= 1'b0;
            chd_q      <= 1'b0;
            chn_q      <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            chq_q      <= chq_d;
            chd_q      <= chd_d;
            chn_q      <= chn_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
        end
    end

    assign outCredit        = credit_q;
    assign outDispense      = dispense_q;
    assign outChangeQuarter = chq_q;
    assign outChangeDime    = chd_q;
    assign outChangeNickel  = chn_q;
    assign outReject        = reject_q;
    assign outBusy          = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: each scenario task drives coins and
// requests, then compares credit and the output pulse vector to hand values.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inQuarter = 1'b0, inDime = 1'b0, inNickel = 1'b0;
    logic       inSelect = 1'b0, inCancel = 1'b0;
    logic [9:0] outCredit;
    logic       outDispense, outChangeQuarter, outChangeDime, outChangeNickel;
    logic       outReject, outBusy;
    logic [5:0] outs;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vend_controller #(.PRICE(125), .MAX_CREDIT(500), .CW(10)) dut (
        .clk              (clk),
        .reset            (reset),
        .inQuarter        (inQuarter),
        .inDime           (inDime),
        .inNickel         (inNickel),
        .inSelect         (inSelect),
        .inCancel         (inCancel),
        .outCredit        (outCredit),
        .outDispense      (outDispense),
        .outChangeQuarter (outChangeQuarter),
        .outChangeDime    (outChangeDime),
        .outChangeNickel  (outChangeNickel),
        .outReject        (outReject),
        .outBusy          (outBusy)
    );

    always #5 clk = ~clk;

    // {dispense, chgQ, chgD, chgN, reject, busy}
    assign outs = {outDispense, outChangeQuarter, outChangeDime, outChangeNickel, outReject, outBusy};

    // Drive one cycle of inputs from a negedge; return on the next negedge,
    // where the registered response to those inputs is visible.
    task automatic step(input logic q, input logic d, input logic n, input logic s, input logic c);
        inQuarter = q; inDime = d; inNickel = n; inSelect = s; inCancel = c;
        @(negedge clk);
        inQuarter = 1'b0; inDime = 1'b0; inNickel = 1'b0; inSelect = 1'b0; inCancel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_coins(input int nq, input int nd, input int nn);
        for (int i = 0; i < nq; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < nd; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < nn; i++) step(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (outCredit !== 10'd0) $display("FAIL reset_credit got=%0d exp=0", outCredit); else pass_cnt++;
        total_cnt++; if (outs !== 6'b000000) $display("FAIL reset_outs got=%b exp=000000", outs); else pass_cnt++;
        step(0, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL idle_select outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 1);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL idle_cancel outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_vend_dime();
        int exp_credit[6] = '{25, 50, 75, 100, 125, 135};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(1, 0, 0, 0, 0); else step(0, 1, 0, 0, 0);
            total_cnt++;
            if (outCredit !== 10'(exp_credit[i]) || outReject !== 1'b0)
                $display("FAIL coin_accum[%0d] credit=%0d rej=%b exp=%0d/0", i, outCredit, outReject, exp_credit[i]);
            else pass_cnt++;
        end
        step(0, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b100001 || outCredit !== 10'd10) $display("FAIL vend outs=%b credit=%0d exp=100001/10", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b001000 || outCredit !== 10'd0) $display("FAIL change_dime outs=%b credit=%0d exp=001000/0", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b000000) $display("FAIL after_vend outs=%b exp=000000", outs); else pass_cnt++;
        $display("test_vend_dime done");
    endtask

    task automatic test_cancel();
        add_coins(1, 1, 1);
        total_cnt++; if (outCredit !== 10'd40) $display("FAIL cancel_build credit=%0d exp=40", outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 1);
        total_cnt++; if (outs !== 6'b010001 || outCredit !== 10'd15) $display("FAIL cancel_q outs=%b credit=%0d exp=010001/15", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b001001 || outCredit !== 10'd5) $display("FAIL cancel_d outs=%b credit=%0d exp=001001/5", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b000100 || outCredit !== 10'd0) $display("FAIL cancel_n outs=%b credit=%0d exp=000100/0", outs, outCredit); else pass_cnt++;
        $display("test_cancel done");
    endtask

    task automatic test_select_low();
        add_coins(4, 0, 0);
        step(0, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd100) $display("FAIL select_low outs=%b credit=%0d exp=000000/100", outs, outCredit); else pass_cnt++;
        step(1, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd125) $display("FAIL coin_beats_select outs=%b credit=%0d exp=000000/125", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b100001 || outCredit !== 10'd0) $display("FAIL exact_vend outs=%b credit=%0d exp=100001/0", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL exact_vend_idle outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        $display("test_select_low done");
    endtask

    task automatic test_max_credit();
        add_coins(19, 1, 1);
        total_cnt++; if (outCredit !== 10'd490) $display("FAIL max_build credit=%0d exp=490", outCredit); else pass_cnt++;
        step(1, 0, 0, 0, 0);
        total_cnt++; if (outReject !== 1'b1 || outCredit !== 10'd490) $display("FAIL over_reject rej=%b credit=%0d exp=1/490", outReject, outCredit); else pass_cnt++;
        step(0, 0, 1, 0, 0);
        total_cnt++; if (outReject !== 1'b0 || outCredit !== 10'd495) $display("FAIL nickel_495 rej=%b credit=%0d exp=0/495", outReject, outCredit); else pass_cnt++;
        step(1, 1, 0, 0, 0);
        total_cnt++; if (outReject !== 1'b1 || outCredit !== 10'd495) $display("FAIL multi_reject rej=%b credit=%0d exp=1/495", outReject, outCredit); else pass_cnt++;
        step(0, 0, 1, 0, 0);
        total_cnt++; if (outReject !== 1'b0 || outCredit !== 10'd500) $display("FAIL exact_max rej=%b credit=%0d exp=0/500", outReject, outCredit); else pass_cnt++;
        step(0, 0, 1, 0, 0);
        total_cnt++; if (outReject !== 1'b1 || outCredit !== 10'd500) $display("FAIL full_reject rej=%b credit=%0d exp=1/500", outReject, outCredit); else pass_cnt++;
        $display("test_max_credit done");
    endtask

    task automatic test_reset_mid_change();
        // Continues from 500 credit left by test_max_credit.
        step(0, 0, 1, 0, 1);
        total_cnt++; if (outs !== 6'b010011 || outCredit !== 10'd475) $display("FAIL cancel_coin_reject outs=%b credit=%0d exp=010011/475", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b010001 || outCredit !== 10'd450) $display("FAIL second_quarter outs=%b credit=%0d exp=010001/450", outs, outCredit); else pass_cnt++;
        reset = 1'b1;
        step(0, 0, 0, 0, 0);
        reset = 1'b0;
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL mid_change_reset outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL post_reset_idle outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        $display("test_reset_mid_change done");
    endtask

    task automatic test_coin_during_vend();
        add_coins(5, 1, 0);
        step(0, 0, 0, 1, 0);
        total_cnt++; if (outs !== 6'b100001 || outCredit !== 10'd10) $display("FAIL vend2 outs=%b credit=%0d exp=100001/10", outs, outCredit); else pass_cnt++;
        step(0, 0, 1, 1, 1);
        total_cnt++; if (outs !== 6'b001010 || outCredit !== 10'd0) $display("FAIL busy_coin_reject outs=%b credit=%0d exp=001010/0", outs, outCredit); else pass_cnt++;
        step(0, 0, 0, 0, 0);
        total_cnt++; if (outs !== 6'b000000 || outCredit !== 10'd0) $display("FAIL busy_done outs=%b credit=%0d exp=000000/0", outs, outCredit); else pass_cnt++;
        $display("test_coin_during_vend done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vend_dime();
        test_cancel();
        test_select_low();
        test_max_credit();
        test_reset_mid_change();
        test_coin_during_vend();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Sequencing controller for the vending machine. It accepts validated coin pulses, accumulates credit in cents, and dispenses an item when the credit reaches the price. It then returns change greedily, one coin per cycle, using quarters, dimes and nickels. It sits between the coin-acceptor front end and the dispense/change actuators, and exposes live credit for the display.

Parameters:
PRICE, 125, item price in cents; must be a multiple of 5 and not exceed MAX_CREDIT
MAX_CREDIT, 500, maximum accumulated credit in cents; must be a multiple of 5 and at most 1023
CW, 10, credit width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
inQuarter  input  1  one-cycle pulse: 25c coin inserted
inDime  input  1  one-cycle pulse: 10c coin inserted
inNickel  input  1  one-cycle pulse: 5c coin inserted
inSelect  input  1  one-cycle pulse: purchase request
inCancel  input  1  one-cycle pulse: refund all credit
outCredit  output  CW  current credit in cents (registered)
outDispense  output  1  one-cycle pulse: release item
outChangeQuarter  output  1  one-cycle pulse: eject 25c
outChangeDime  output  1  one-cycle pulse: eject 10c
outChangeNickel  output  1  one-cycle pulse: eject 5c
outReject  output  1  one-cycle pulse: inserted coin returned, not credited
outBusy  output  1  high while in VEND or CHANGE

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset has priority over everything: next edge gives state IDLE, outCredit=0, and all pulse outputs and outBusy at 0. Reset applies in any state, including mid-CHANGE; change not yet ejected is forfeited.
- All outputs are registered. Each response appears on the clock edge after the stimulus is sampled (latency 1).
- State IDLE (credit=0) and state CREDIT (credit>0) accept coins.
  - Valid coin: exactly one of inQuarter/inDime/inNickel is high, and credit+value <= MAX_CREDIT. Credit increases by the coin value. IDLE moves to CREDIT.
  - Invalid coin: more than one coin line is high, or the coin would exceed MAX_CREDIT. outReject pulses and credit is unchanged.
- Decisions in CREDIT (inCancel beats coin beats inSelect):
  - inCancel: go to CHANGE with the full credit. A coin pulsed in the same cycle is rejected (outReject).
  - Coin: accept or reject it as above. An inSelect pulsed in the same cycle is ignored and must be reasserted.
  - inSelect alone with credit >= PRICE: go to VEND.
  - inSelect alone with credit < PRICE: ignored, no output.
- inSelect and inCancel in IDLE are ignored.
- VEND lasts one cycle: outDispense pulses, credit decreases by PRICE, and outBusy=1. Next state is CHANGE if the remaining credit is >0, otherwise IDLE.
- CHANGE ejects one coin per cycle, greedy:
  - credit >= 25: quarter
  - else credit >= 10: dime
  - else: nickel
  - The matching outChange* pulses and credit decreases by that coin value in the same edge.
  - When credit reaches 0, go to IDLE.
  - outBusy=1 throughout.
- Coin pulses during VEND or CHANGE are rejected (outReject). inSelect and inCancel during VEND or CHANGE are ignored.
- At most one of outDispense and outChange* is high in any cycle.
- Credit never underflows and never exceeds MAX_CREDIT. All arithmetic is unsigned CW-bit, and the credit is always a multiple of 5.

Decomposition:
- Package vend_pkg holds:
  - state enum: IDLE, CREDIT, VEND, CHANGE
  - coin value constants: VAL_QUARTER=25, VAL_DIME=10, VAL_NICKEL=5
  - coin-select encoding used by the change path
- One natural sub-module, vend_change_sel: combinational greedy selector. It takes the credit and returns the coin to eject and that coin's value. It is used in the CHANGE state and is testable in isolation.

Test Plan:
- Reset, then insert Q,Q,Q,Q,Q,D -> credit 25,50,75,100,125,135. Pulse inSelect -> outDispense for 1 cycle, credit 10. Next cycle outChangeDime, credit 0, IDLE, outBusy low.
- Insert Q,D,N (credit 40), pulse inCancel -> outChangeQuarter, then outChangeDime, then outChangeNickel on 3 consecutive cycles. Credit 15, 5, 0. No outDispense.
- Credit 100, pulse inSelect -> no response, credit stays 100. Then insert Q and inSelect in the same cycle -> credit 125, no dispense. Reassert inSelect -> outDispense, credit 0.
- Credit 490, insert Q -> outReject, credit 490. Insert N -> credit 495. Assert inQuarter and inDime together -> outReject, credit 495.
- Credit 135, select, and insert N during CHANGE -> outReject, change still dime only.
- Credit 500, cancel, and assert reset after the 2nd outChangeQuarter -> next edge credit 0, IDLE, all pulses low.
